// File: rtl/arf074b064e1r1w0cbbehsaa4acw_bist_fail_encoder.sv
// ---------------------------------------------------------------------------
// arf074b064e1r1w0cbbehsaa4acw_bist_fail_encoder
//
// Purpose:
//   Turns BIST per-entry compare-fail vectors (multi-hot, one bit per array
//   entry) back into binary entry indices. Each encoded fail record goes into
//   a small output FIFO with a valid/ready handshake. The block also keeps
//   sticky fail status and a saturating count of pushed records.
//
// Optional feature (compile-time macro):
//   ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
//     defined   : a multi-hot vector is serialised into one record per set bit,
//                 lowest index first. A SERIAL state holds off new vectors
//                 until the last bit has been pushed.
//     undefined : each nonzero vector gives one record (its lowest index).
//                 The other set bits are dropped; multi_hit records the loss.
//
// Ports:
//   clk        in   1          clock, all state on the rising edge
//   rst_n      in   1          asynchronous active-low reset
//   clr        in   1          synchronous clear of FIFO, status, count and FSM
//   in_valid   in   1          fail vector valid
//   in_ready   out  1          encoder can accept a vector this cycle
//   in_vec     in   IN_WIDTH   fail vector, bit i set = entry i failed
//   out_valid  out  1          fail record valid (FIFO head)
//   out_ready  in   1          consumer accepts the head record
//   out_idx    out  OUT_WIDTH  failing entry index of the head record
//   out_multi  out  1          head record came from a multi-hot vector
//   fail_any   out  1          sticky: a nonzero vector was accepted
//   multi_hit  out  1          sticky: a vector with >1 bit set was accepted
//   fail_cnt   out  CNT_WIDTH  records pushed, saturating at all-ones
// ---------------------------------------------------------------------------
module arf074b064e1r1w0cbbehsaa4acw_bist_fail_encoder #(
    parameter int IN_WIDTH   = 74,
    parameter int OUT_WIDTH  = $clog2(IN_WIDTH),
    parameter int CNT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_idx,
    output logic                 out_multi,
    output logic                 fail_any,
    output logic                 multi_hit,
    output logic [CNT_WIDTH-1:0] fail_cnt
);

    localparam int                   CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]        DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]        CW_ONE_C  = CW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX_C = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE_C = CNT_WIDTH'(1);
    localparam logic [IN_WIDTH-1:0]  VEC_ONE_C = IN_WIDTH'(1);

    // Index of the lowest set bit. The loop runs from high to low, so the
    // last match (the lowest bit) wins. A zero vector gives index 0.
    function automatic logic [OUT_WIDTH-1:0] lowest_idx(input logic [IN_WIDTH-1:0] vec);
        logic [OUT_WIDTH-1:0] idx;
        idx = {OUT_WIDTH{1'b0}};
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = OUT_WIDTH'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Vector with its lowest set bit removed.
    function automatic logic [IN_WIDTH-1:0] clear_lowest(input logic [IN_WIDTH-1:0] vec);
        return vec & (vec - VEC_ONE_C);
    endfunction

    // True when more than one bit is set.
    function automatic logic is_multi(input logic [IN_WIDTH-1:0] vec);
        return (clear_lowest(vec) != {IN_WIDTH{1'b0}});
    endfunction

    // Shift-register FIFO: slot 0 is always the head, so the output record
    // comes straight from flops. Slots at or above count_r are kept at zero.
    logic [OUT_WIDTH-1:0] fifo_idx_r   [FIFO_DEPTH];
    logic                 fifo_multi_r [FIFO_DEPTH];
    logic [OUT_WIDTH-1:0] fifo_idx_s   [FIFO_DEPTH];
    logic                 fifo_multi_s [FIFO_DEPTH];
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_s;
    logic                 out_valid_r;
    logic                 out_valid_s;

    logic                 fail_any_r;
    logic                 fail_any_s;
    logic                 multi_hit_r;
    logic                 multi_hit_s;
    logic [CNT_WIDTH-1:0] fail_cnt_r;
    logic [CNT_WIDTH-1:0] fail_cnt_s;

    logic                 idle_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 push_s;
    logic [OUT_WIDTH-1:0] push_idx_s;
    logic                 push_multi_s;
    logic                 set_any_s;
    logic                 set_multi_s;

`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SERIAL = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [IN_WIDTH-1:0]  residual_r;
    logic [IN_WIDTH-1:0]  residual_s;

    assign idle_s = (state_r == ST_IDLE);
`else
    assign idle_s = 1'b1;
`endif

    // in_ready uses only the registered FIFO count. A same-cycle pop does not
    // open a slot for a new vector. It is held low while reset is applied.
    assign in_ready_s = rst_n & (count_r < DEPTH_C) & idle_s & ~clr;
    assign accept_s   = in_valid & in_ready_s;
    assign pop_s      = out_valid_r & out_ready;

    // Record source selection (accepted vector or serial residual) and FSM next state.
    always_comb begin
        push_s       = 1'b0;
        push_idx_s   = {OUT_WIDTH{1'b0}};
        push_multi_s = 1'b0;
        set_any_s    = 1'b0;
        set_multi_s  = 1'b0;
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
        state_s      = state_r;
        residual_s   = residual_r;
`endif
        if (clr) begin
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
            state_s    = ST_IDLE;
            residual_s = {IN_WIDTH{1'b0}};
`endif
        end else if (accept_s && (in_vec != {IN_WIDTH{1'b0}})) begin
            push_s       = 1'b1;
            push_idx_s   = lowest_idx(in_vec);
            // With serialisation this also means "more records follow".
            push_multi_s = is_multi(in_vec);
            set_any_s    = 1'b1;
            set_multi_s  = is_multi(in_vec);
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
            if (is_multi(in_vec)) begin
                residual_s = clear_lowest(in_vec);
                state_s    = ST_SERIAL;
            end else begin
                residual_s = {IN_WIDTH{1'b0}};
                state_s    = ST_IDLE;
            end
`endif
        end
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
        else if ((state_r == ST_SERIAL) && (count_r < DEPTH_C)) begin
            push_s       = 1'b1;
            push_idx_s   = lowest_idx(residual_r);
            push_multi_s = is_multi(residual_r);
            residual_s   = clear_lowest(residual_r);
            // After the last residual bit is pushed, return to IDLE.
            if (is_multi(residual_r)) begin
                state_s = ST_SERIAL;
            end else begin
                state_s = ST_IDLE;
            end
        end
`endif
        else begin
            push_s = 1'b0;
        end
    end

    // FIFO next state. A pop shifts toward the head first, then a push
    // writes the first free slot, so pushing and popping together keeps order.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_idx_s[i]   = fifo_idx_r[i];
            fifo_multi_s[i] = fifo_multi_r[i];
        end
        count_s = count_r;
        if (clr) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_idx_s[i]   = {OUT_WIDTH{1'b0}};
                fifo_multi_s[i] = 1'b0;
            end
            count_s = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    fifo_idx_s[i]   = fifo_idx_r[i+1];
                    fifo_multi_s[i] = fifo_multi_r[i+1];
                end
                fifo_idx_s[FIFO_DEPTH-1]   = {OUT_WIDTH{1'b0}};
                fifo_multi_s[FIFO_DEPTH-1] = 1'b0;
                count_s = count_r - CW_ONE_C;
            end else begin
                count_s = count_r;
            end
            if (push_s) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (CW'(i) == count_s) begin
                        fifo_idx_s[i]   = push_idx_s;
                        fifo_multi_s[i] = push_multi_s;
                    end else begin
                        fifo_idx_s[i]   = fifo_idx_s[i];
                        fifo_multi_s[i] = fifo_multi_s[i];
                    end
                end
                count_s = count_s + CW_ONE_C;
            end else begin
                count_s = count_s;
            end
        end
        out_valid_s = (count_s != {CW{1'b0}});
    end

    // Sticky status flags and saturating record counter.
    always_comb begin
        fail_any_s  = fail_any_r;
        multi_hit_s = multi_hit_r;
        fail_cnt_s  = fail_cnt_r;
        if (clr) begin
            fail_any_s  = 1'b0;
            multi_hit_s = 1'b0;
            fail_cnt_s  = {CNT_WIDTH{1'b0}};
        end else begin
            fail_any_s  = fail_any_r | set_any_s;
            multi_hit_s = multi_hit_r | set_multi_s;
            if (push_s && (fail_cnt_r != CNT_MAX_C)) begin
                fail_cnt_s = fail_cnt_r + CNT_ONE_C;
            end else begin
                fail_cnt_s = fail_cnt_r;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_idx_r[i]   <= {OUT_WIDTH{1'b0}};
                fifo_multi_r[i] <= 1'b0;
            end
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            fail_any_r  <= 1'b0;
            multi_hit_r <= 1'b0;
            fail_cnt_r  <= {CNT_WIDTH{1'b0}};
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
            state_r     <= ST_IDLE;
            residual_r  <= {IN_WIDTH{1'b0}};
`endif
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_idx_r[i]   <= fifo_idx_s[i];
                fifo_multi_r[i] <= fifo_multi_s[i];
            end
            count_r     <= count_s;
            out_valid_r <= out_valid_s;
            fail_any_r  <= fail_any_s;
            multi_hit_r <= multi_hit_s;
            fail_cnt_r  <= fail_cnt_s;
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
            state_r     <= state_s;
            residual_r  <= residual_s;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_idx   = fifo_idx_r[0];
    assign out_multi = fifo_multi_r[0];
    assign fail_any  = fail_any_r;
    assign multi_hit = multi_hit_r;
    assign fail_cnt  = fail_cnt_r;

endmodule

// File: tb/tb_arf074b064e1r1w0cbbehsaa4acw_bist_fail_encoder.sv
// Self-checking bench for the BIST fail encoder. A queue-based reference
// model (records FIFO, pending serial indices, sticky flags, saturating
// counter) is stepped once per clock and compared with the DUT.
module tb_arf074b064e1r1w0cbbehsaa4acw_bist_fail_encoder;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [73:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_idx;
    logic        out_multi;
    logic        fail_any;
    logic        multi_hit;
    logic [7:0]  fail_cnt;

    int n_cmp;
    int n_err;

    // reference model state
    int m_idx_q[$];
    bit m_mul_q[$];
    int m_pend_q[$];
    int m_cnt;
    bit m_any;
    bit m_mh;

    arf074b064e1r1w0cbbehsaa4acw_bist_fail_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_multi (out_multi),
        .fail_any  (fail_any),
        .multi_hit (multi_hit),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_idx_q.delete();
        m_mul_q.delete();
        m_pend_q.delete();
        m_cnt = 0;
        m_any = 1'b0;
        m_mh  = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_idx_q.size() > 0));
        if (m_idx_q.size() > 0) begin
            check("out_idx", 32'(out_idx), 32'(m_idx_q[0]));
            check("out_multi", 32'(out_multi), 32'(m_mul_q[0]));
        end
        check("fail_any", 32'(fail_any), 32'(m_any));
        check("multi_hit", 32'(multi_hit), 32'(m_mh));
        check("fail_cnt", 32'(fail_cnt), 32'(m_cnt));
    endtask

    // One clock: drive inputs, check in_ready before the edge, advance the
    // model, then check registered outputs just after the edge.
    task automatic step(input bit v, input logic [73:0] vec, input bit ordy, input bit c);
        int bits[$];
        bit exp_rdy;
        bit do_pop;
        bit have_push;
        bit pm;
        int pidx;
        in_valid  = v;
        in_vec    = vec;
        out_ready = ordy;
        clr       = c;
        @(negedge clk);
        exp_rdy = (m_idx_q.size() < 2) && (m_pend_q.size() == 0) && !c;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        for (int i = 0; i < 74; i++) begin
            if (vec[i]) bits.push_back(i);
        end
        if (c) begin
            model_reset();
        end else begin
            have_push = 1'b0;
            pm = 1'b0;
            pidx = 0;
            do_pop = (m_idx_q.size() > 0) && ordy;
            if (v && exp_rdy && bits.size() > 0) begin
                pidx = bits[0];
                pm = (bits.size() > 1);
                m_any = 1'b1;
                if (pm) m_mh = 1'b1;
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
                for (int k = 1; k < bits.size(); k++) m_pend_q.push_back(bits[k]);
`endif
                have_push = 1'b1;
            end else if (m_pend_q.size() > 0 && m_idx_q.size() < 2) begin
                pidx = m_pend_q.pop_front();
                pm = (m_pend_q.size() > 0);
                have_push = 1'b1;
            end
            if (do_pop) begin
                void'(m_idx_q.pop_front());
                void'(m_mul_q.pop_front());
            end
            if (have_push) begin
                m_idx_q.push_back(pidx);
                m_mul_q.push_back(pm);
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [73:0] rand_vec(input int mode);
        logic [73:0] v;
        logic [95:0] w;
        v = '0;
        case (mode)
            0: v = '0;
            1: v[$urandom_range(73, 0)] = 1'b1;
            2: begin
                v[$urandom_range(73, 0)] = 1'b1;
                v[$urandom_range(73, 0)] = 1'b1;
                v[$urandom_range(73, 0)] = 1'b1;
            end
            default: begin
                w = {$urandom, $urandom, $urandom};
                v = w[73:0];
            end
        endcase
        return v;
    endfunction

    initial begin
        logic [73:0] v;
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;

        // 1: reset state, in_ready low during reset and high after release
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check_outputs();
        check("rst_out_idx", 32'(out_idx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // 2: top entry, then a zero vector
        v = '0; v[73] = 1'b1;
        step(1'b1, v, 1'b1, 1'b0);
        check("t2_idx", 32'(out_idx), 32'd73);
        check("t2_multi", 32'(out_multi), 32'd0);
        check("t2_cnt", 32'(fail_cnt), 32'd1);
        step(1'b1, 74'd0, 1'b1, 1'b0);
        check("t2_zero_cnt", 32'(fail_cnt), 32'd1);
        step(1'b0, 74'd0, 1'b1, 1'b0);

        // 3: back-pressure, full FIFO, pop plus offer not accepted, in-order drain
        step(1'b0, 74'd0, 1'b0, 1'b1);
        v = '0; v[3] = 1'b1; step(1'b1, v, 1'b0, 1'b0);
        v = '0; v[5] = 1'b1; step(1'b1, v, 1'b0, 1'b0);
        v = '0; v[7] = 1'b1; step(1'b1, v, 1'b0, 1'b0);
        step(1'b1, v, 1'b1, 1'b0);
        check("t3_second", 32'(out_idx), 32'd5);
        step(1'b0, 74'd0, 1'b1, 1'b0);
        step(1'b0, 74'd0, 1'b1, 1'b0);

        // 4: multi-hot vector {2,9,40}
        step(1'b0, 74'd0, 1'b1, 1'b1);
        v = '0; v[2] = 1'b1; v[9] = 1'b1; v[40] = 1'b1;
        step(1'b1, v, 1'b1, 1'b0);
        check("t4_first", 32'(out_idx), 32'd2);
        check("t4_first_m", 32'(out_multi), 32'd1);
        repeat (4) step(1'b0, 74'd0, 1'b1, 1'b0);
`ifdef ARF074B064E1R1W0CBBEHSAA4ACW_BIST_ENC_SERIAL_EN
        check("t4_cnt", 32'(fail_cnt), 32'd3);
`else
        check("t4_cnt", 32'(fail_cnt), 32'd1);
`endif
        check("t4_mh", 32'(multi_hit), 32'd1);

        // 1 (mid-stream): reset with FIFO full
        v = '0; v[11] = 1'b1; step(1'b1, v, 1'b0, 1'b0);
        v = '0; v[12] = 1'b1; step(1'b1, v, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_outputs();
        check("mid_rst_idx", 32'(out_idx), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);

        // 5: counter saturation
        step(1'b0, 74'd0, 1'b1, 1'b1);
        for (int n = 0; n < 260; n++) step(1'b1, rand_vec(1), 1'b1, 1'b0);
        repeat (3) step(1'b0, 74'd0, 1'b1, 1'b0);
        check("t5_sat", 32'(fail_cnt), 32'd255);
        step(1'b1, rand_vec(1), 1'b1, 1'b0);
        check("t5_hold", 32'(fail_cnt), 32'd255);

        // 6: clr while serialising with records queued
        step(1'b0, 74'd0, 1'b0, 1'b1);
        v = '0; v[1] = 1'b1; v[4] = 1'b1; v[6] = 1'b1; v[8] = 1'b1; v[10] = 1'b1;
        step(1'b1, v, 1'b0, 1'b0);
        step(1'b0, 74'd0, 1'b0, 1'b0);
        step(1'b0, 74'd0, 1'b0, 1'b1);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_cnt", 32'(fail_cnt), 32'd0);
        check("t6_any", 32'(fail_any), 32'd0);
        step(1'b0, 74'd0, 1'b1, 1'b0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(99, 0) < 60), rand_vec($urandom_range(3, 0)),
                 ($urandom_range(99, 0) < 70), ($urandom_range(99, 0) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
